// File: rtl/branch_tracker.sv
// branch_tracker: sequences branch prediction requests to an external predictor,
// holds up to DEPTH unresolved predictions in an in-order FIFO, and checks each
// resolution from execute against the oldest stored prediction.
// Optional feature macro: MISPRED_CNT_EN (saturating misprediction counter).
// With MISPRED_CNT_EN undefined, mispred_cnt is tied to zero.
module branch_tracker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     br_valid,
  output logic                     br_ready,
  output logic                     pred_valid,
  output logic                     pred_taken,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     res_ready,
  output logic                     mispredict,
  output logic                     request,
  output logic                     result,
  output logic                     taken,
  input  logic                     prediction,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic [CNT_W-1:0]         mispred_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] CAPT = 2'd2;
  localparam logic [1:0] RES  = 2'd3;

  logic [1:0]       state_q;
  logic [1:0]       state_nxt;
  logic             fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             res_taken_q;
  logic             push;
  logic             pop;

  assign outstanding = occ_q;

  // Next-state and handshake/pulse decode; resolution has priority over a new branch.
  always_comb begin
    state_nxt  = state_q;
    br_ready   = 1'b0;
    res_ready  = 1'b0;
    request    = 1'b0;
    pred_valid = 1'b0;
    pred_taken = 1'b0;
    result     = 1'b0;
    taken      = 1'b0;
    mispredict = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        // rst_n gating keeps the ready outputs low while reset is held
        if (rst_n && res_valid && (occ_q != '0)) begin
          res_ready = 1'b1;
          state_nxt = RES;
        end else if (rst_n && br_valid && (occ_q < OCC_W'(DEPTH))) begin
          br_ready  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        request   = 1'b1;
        state_nxt = CAPT;
      end
      CAPT: begin
        pred_valid = 1'b1;
        pred_taken = prediction;
        push       = 1'b1;
        state_nxt  = IDLE;
      end
      RES: begin
        result     = 1'b1;
        taken      = res_taken_q;
        mispredict = (res_taken_q != fifo_q[rd_ptr_q]);
        pop        = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Outcome latched at resolution acceptance, used during RES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         res_taken_q <= 1'b0;
    else if (res_ready) res_taken_q <= res_taken;
  end

  // Prediction FIFO storage and pointers; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= prediction;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Occupancy count; push (CAPT) and pop (RES) are mutually exclusive by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    occ_q <= '0;
    else if (push) occ_q <= occ_q + OCC_W'(1);
    else if (pop)  occ_q <= occ_q - OCC_W'(1);
  end

`ifdef MISPRED_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating misprediction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt_q <= '0;
    else if (mispredict && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign mispred_cnt = cnt_q;
`else
  assign mispred_cnt = '0;
`endif

endmodule
